// File: rtl/y86_wb_regfile.sv
// y86_wb_regfile: Y86-64 SEQ write-back stage and architectural register file.
// Decodes dstE/dstM from icode/cnd/rA/rB and commits valE/valM on the clock edge.
// It also provides two combinational read ports, a saturating retired-write counter
// and a sticky illegal-icode flag.
// Optional macro WB_BYPASS_EN forwards same-cycle write data to the read ports.
module y86_wb_regfile #(
   parameter int                 DATA_W   = 64,
   parameter int                 NREG     = 15,
   parameter int                 RSP_ID   = 4,
   parameter logic [DATA_W-1:0]  RSP_INIT = '0,
   parameter int                 CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_valid,
   input  logic [3:0]        icode,
   input  logic              cnd,
   input  logic [3:0]        rA,
   input  logic [3:0]        rB,
   input  logic [DATA_W-1:0] valE,
   input  logic [DATA_W-1:0] valM,
   input  logic [3:0]        srcA,
   input  logic [3:0]        srcB,
   output logic [DATA_W-1:0] valA,
   output logic [DATA_W-1:0] valB,
   output logic [3:0]        dstE,
   output logic [3:0]        dstM,
   output logic [CNT_W-1:0]  wb_count,
   output logic              bad_icode
);

   localparam logic [3:0] NONE   = 4'hF;
   localparam logic [4:0] NREG_L = 5'(NREG);
   localparam logic [3:0] RSP_L  = 4'(RSP_ID);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              bad_q, bad_d;
   logic [3:0]        dst_e_raw, dst_m_raw;
   logic              wrote;

   // Destination decode; illegal icodes fall through to "none" so they never write
   always_comb begin
      dst_e_raw = NONE;
      dst_m_raw = NONE;
      case (icode)
         4'd2:                   dst_e_raw = cnd ? rB : NONE;
         4'd3, 4'd6:             dst_e_raw = rB;
         4'd8, 4'd9, 4'd10:      dst_e_raw = RSP_L;
         4'd11: begin
            dst_e_raw = RSP_L;
            dst_m_raw = rA;
         end
         4'd5:                   dst_m_raw = rA;
         default: ;
      endcase
      dstE = ({1'b0, dst_e_raw} < NREG_L) ? dst_e_raw : NONE;
      dstM = ({1'b0, dst_m_raw} < NREG_L) ? dst_m_raw : NONE;
   end

   // Next register state; the M write is applied last so popq %rsp keeps valM
   always_comb begin
      regs_d = regs_q;
      if (wb_valid) begin
         for (int i = 0; i < NREG; i++) begin
            if (dstE == 4'(i)) regs_d[i] = valE;
            if (dstM == 4'(i)) regs_d[i] = valM;
         end
      end
   end

   // Next counter and sticky flag state; the counter saturates instead of wrapping
   always_comb begin
      wrote = wb_valid && ((dstE != NONE) || (dstM != NONE));
      cnt_d = cnt_q;
      if (wrote && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
      bad_d = bad_q | (wb_valid && (icode >= 4'd12));
   end

   // State update; reset wins over a retiring instruction in the same cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= (i == RSP_ID) ? RSP_INIT : '0;
         end
         cnt_q <= '0;
         bad_q <= 1'b0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
         bad_q  <= bad_d;
      end
   end

   // Read ports; IDs 15 or >= NREG match no entry and read as zero
   always_comb begin
      valA = '0;
      valB = '0;
      for (int i = 0; i < NREG; i++) begin
         if (srcA == 4'(i)) valA = regs_q[i];
         if (srcB == 4'(i)) valB = regs_q[i];
      end
`ifdef WB_BYPASS_EN
      if (wb_valid && (dstE != NONE) && (dstE == srcA)) valA = valE;
      if (wb_valid && (dstM != NONE) && (dstM == srcA)) valA = valM;
      if (wb_valid && (dstE != NONE) && (dstE == srcB)) valB = valE;
      if (wb_valid && (dstM != NONE) && (dstM == srcB)) valB = valM;
`else
      // Stored contents only; writes become visible the cycle after the edge
`endif
   end

   assign wb_count  = cnt_q;
   assign bad_icode = bad_q;

endmodule

// File: tb/tb_y86_wb_regfile.sv
// Directed testbench for y86_wb_regfile (NREG=8, CNT_W=4, RSP_INIT=0x100).
module tb_y86_wb_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [3:0]  icode;
   logic        cnd;
   logic [3:0]  rA, rB;
   logic [63:0] valE, valM;
   logic [3:0]  srcA, srcB;
   logic [63:0] valA, valB;
   logic [3:0]  dstE, dstM;
   logic [3:0]  wb_count;
   logic        bad_icode;

   int checks = 0;
   int errors = 0;

   y86_wb_regfile #(
      .DATA_W(64), .NREG(8), .RSP_ID(4), .RSP_INIT(64'h100), .CNT_W(4)
   ) dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode), .cnd(cnd),
      .rA(rA), .rB(rB), .valE(valE), .valM(valM), .srcA(srcA), .srcB(srcB),
      .valA(valA), .valB(valB), .dstE(dstE), .dstM(dstM),
      .wb_count(wb_count), .bad_icode(bad_icode)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; wb_valid = 1'b0; icode = 4'd0; cnd = 1'b0;
      rA = 4'hF; rB = 4'hF; valE = '0; valM = '0; srcA = 4'd0; srcB = 4'd4;
      step(); step();
      rst = 1'b0;
      #1;
      // reset state
      check("rst_valA_r0", valA, 64'h0);
      check("rst_valB_r4", valB, 64'h100);
      check("rst_count", 64'(wb_count), 64'd0);
      check("rst_bad", 64'(bad_icode), 64'd0);

      // irmovq -> r2
      icode = 4'd3; rB = 4'd2; valE = 64'hDEAD; wb_valid = 1'b1;
      #1;
      check("irm_dstE", 64'(dstE), 64'd2);
      check("irm_dstM", 64'(dstM), 64'd15);
      step();
      wb_valid = 1'b0; srcA = 4'd2;
      #1;
      check("irm_read_r2", valA, 64'hDEAD);
      check("irm_count", 64'(wb_count), 64'd1);

      // cmov not taken
      icode = 4'd2; cnd = 1'b0; rB = 4'd3; valE = 64'd5; wb_valid = 1'b1;
      #1;
      check("cmovnt_dstE", 64'(dstE), 64'd15);
      step();
      wb_valid = 1'b0; srcA = 4'd3;
      #1;
      check("cmovnt_r3", valA, 64'h0);
      check("cmovnt_count", 64'(wb_count), 64'd1);

      // cmov taken
      cnd = 1'b1; wb_valid = 1'b1;
      #1;
      check("cmovt_dstE", 64'(dstE), 64'd3);
      step();
      wb_valid = 1'b0;
      #1;
      check("cmovt_r3", valA, 64'd5);
      check("cmovt_count", 64'(wb_count), 64'd2);

      // pushq decodes rsp as E destination (combinational only)
      icode = 4'd10; cnd = 1'b0; rA = 4'd1; rB = 4'hF;
      #1;
      check("push_dstE", 64'(dstE), 64'd4);
      check("push_dstM", 64'(dstM), 64'd15);

      // popq %rsp: valM wins the collision
      icode = 4'd11; rA = 4'd4; valE = 64'h108; valM = 64'h55; wb_valid = 1'b1;
      #1;
      check("pop_dstE", 64'(dstE), 64'd4);
      check("pop_dstM", 64'(dstM), 64'd4);
      step();
      wb_valid = 1'b0; srcB = 4'd4;
      #1;
      check("pop_r4", valB, 64'h55);
      check("pop_count", 64'(wb_count), 64'd3);

      // mrmovq -> r1 via valM
      icode = 4'd5; rA = 4'd1; rB = 4'd2; valE = 64'h999; valM = 64'h77; wb_valid = 1'b1;
      #1;
      check("mrm_dstE", 64'(dstE), 64'd15);
      check("mrm_dstM", 64'(dstM), 64'd1);
      step();
      wb_valid = 1'b0; srcA = 4'd1; srcB = 4'd2;
      #1;
      check("mrm_r1", valA, 64'h77);
      check("mrm_r2_kept", valB, 64'hDEAD);
      check("mrm_count", 64'(wb_count), 64'd4);

      // destination >= NREG is forced to none; out-of-range read is zero
      icode = 4'd3; rB = 4'd9; valE = 64'h1234; wb_valid = 1'b1;
      #1;
      check("oor_dstE", 64'(dstE), 64'd15);
      step();
      wb_valid = 1'b0; srcA = 4'd9;
      #1;
      check("oor_read", valA, 64'h0);
      check("oor_count", 64'(wb_count), 64'd4);

      // illegal icode: sticky flag, no writes
      icode = 4'd13; rA = 4'd4; rB = 4'd4; valE = 64'hAA; valM = 64'hBB; wb_valid = 1'b1;
      step();
      wb_valid = 1'b0; srcB = 4'd4;
      #1;
      check("ill_bad", 64'(bad_icode), 64'd1);
      check("ill_count", 64'(wb_count), 64'd4);
      check("ill_r4", valB, 64'h55);

      // wb_valid low: hold state, decode still live
      icode = 4'd3; rB = 4'd1; valE = 64'hBAD; srcA = 4'd1;
      #1;
      check("hold_dstE", 64'(dstE), 64'd1);
      step();
      check("hold_r1", valA, 64'h77);
      check("hold_count", 64'(wb_count), 64'd4);
      check("hold_bad", 64'(bad_icode), 64'd1);

      // same-cycle write/read of r7
      icode = 4'd6; rB = 4'd7; valE = 64'h42; srcA = 4'd7; wb_valid = 1'b1;
      #1;
`ifdef WB_BYPASS_EN
      check("byp_valA", valA, 64'h42);
`else
      check("byp_valA", valA, 64'h0);
`endif
      step();
      wb_valid = 1'b0;
      #1;
      check("byp_after", valA, 64'h42);
      check("byp_count", 64'(wb_count), 64'd5);

      // counter saturation at 15 (12 more writes)
      icode = 4'd3; rB = 4'd5; wb_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         valE = 64'(i);
         step();
      end
      wb_valid = 1'b0; srcA = 4'd5;
      #1;
      check("sat_count", 64'(wb_count), 64'd15);
      check("sat_r5", valA, 64'd11);

      // reset has priority over a retiring write
      rst = 1'b1; wb_valid = 1'b1; icode = 4'd3; rB = 4'd2; valE = 64'h1;
      step();
      rst = 1'b0; wb_valid = 1'b0; srcA = 4'd2; srcB = 4'd4;
      #1;
      check("rst2_bad", 64'(bad_icode), 64'd0);
      check("rst2_count", 64'(wb_count), 64'd0);
      check("rst2_r2", valA, 64'h0);
      check("rst2_r4", valB, 64'h100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/y86_wb_regfile.md
Name: y86_wb_regfile

Overview:
- Parametrised write-back stage plus register file for the Y86-64 SEQ datapath.
- Decodes dstE/dstM from icode, cnd, rA and rB, then commits valE/valM into an internal register array on the clock edge.
- Provides two combinational read ports for decode, a retired-write counter and a sticky illegal-icode flag.
- Sits between memory stage outputs (valE, valM) and the decode stage.

Parameters:
- DATA_W, 64, register and value width in bits.
- NREG, 15, number of architectural registers (1..15); IDs >= NREG mean "none".
- RSP_ID, 4, register ID used as the stack pointer.
- RSP_INIT, 0, value loaded into register RSP_ID on reset.
- CNT_W, 16, width of the retired-write counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- wb_valid  in  1  current instruction retires this cycle; no state changes when low.
- icode  in  4  instruction code.
- cnd  in  1  condition result; qualifies cmovXX (icode 2).
- rA  in  4  rA register field.
- rB  in  4  rB register field.
- valE  in  DATA_W  ALU result.
- valM  in  DATA_W  memory read data.
- srcA  in  4  read port A register ID.
- srcB  in  4  read port B register ID.
- valA  out  DATA_W  read data A.
- valB  out  DATA_W  read data B.
- dstE  out  4  decoded E destination; 15 = none.
- dstM  out  4  decoded M destination; 15 = none.
- wb_count  out  CNT_W  number of retired instructions that wrote at least one register.
- bad_icode  out  1  sticky flag, set on a retired illegal icode.

Behaviour:
- Reset (rst high at clk edge):
  - All registers cleared to 0, except register RSP_ID, which loads RSP_INIT.
  - wb_count = 0, bad_icode = 0.
  - rst has priority over wb_valid in the same cycle.
- dstE/dstM decode (combinational, independent of wb_valid):
  - icode 2: dstE = rB if cnd = 1, else 15.
  - icode 3 or 6: dstE = rB.
  - icode 8, 9, 10, 11: dstE = RSP_ID.
  - All other icodes: dstE = 15.
  - icode 5 or 11: dstM = rA; otherwise dstM = 15.
  - Any decoded ID >= NREG is forced to 15 on the output.
- Commit (rising edge, wb_valid = 1, rst = 0):
  - If dstE != 15, reg[dstE] <= valE.
  - If dstM != 15, reg[dstM] <= valM.
  - If dstE == dstM != 15, valM wins (popq %rsp semantics).
  - Write latency is 1 cycle: a read in the cycle after the edge sees the new value.
- Read ports:
  - valA = reg[srcA], valB = reg[srcB], both combinational.
  - srcX = 15 or srcX >= NREG returns 0.
- wb_count:
  - Increments by 1 on a committed edge where at least one write occurred.
  - Saturates at 2^CNT_W - 1; no wrap.
- bad_icode:
  - Set on a committed edge with icode >= 12; no register writes occur for that instruction.
  - Stays set until rst.
- wb_valid = 0: registers, counter and flag hold; dstE/dstM still reflect the inputs.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - A read port whose srcX matches an active same-cycle write (wb_valid = 1, dst != 15) returns the write data instead of the stored value.
  - valM takes precedence over valE when both target srcX.
  - Gives zero-latency write-to-read.
- Undefined: read ports return stored register contents only.

Test Plan:
- Reset: assert rst with RSP_INIT = 0x100 -> valA = 0 for srcA = 0; valB = 0x100 for srcB = 4; wb_count = 0; bad_icode = 0.
- irmovq then read: icode = 3, rB = 2, valE = 0xDEAD, wb_valid = 1 for 1 cycle -> next cycle srcA = 2 gives 0xDEAD; wb_count = 1.
- cmov not taken: icode = 2, cnd = 0, rB = 3, valE = 5 -> dstE = 15; reg3 unchanged; wb_count unchanged.
- popq %rsp collision: icode = 11, rA = 4, valE = 0x108, valM = 0x55 -> reg4 = 0x55; dstE = dstM = 4.
- Illegal icode plus hold: icode = 13 with wb_valid = 1 -> bad_icode = 1 and no writes. Then wb_valid = 0 with icode = 3, rB = 1 -> reg1 unchanged. Then rst -> bad_icode = 0.
- Bypass (WB_BYPASS_EN defined): icode = 6, rB = 7, valE = 0x42, srcA = 7 in the same cycle -> valA = 0x42 before the edge. With the macro undefined -> valA shows the old value.
